fetch_prefetch_queue: RTL

//  Parametrised successor to the single-register fetch stage. Holds the fetch PC and

---
 rtl/fetch_prefetch_queue.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential fetch into a 1-cycle imem, DEPTH-entry prefetch queue, redirect flush.
// Optional FETCH_BYPASS_EN: a response into an empty queue drives decode in the same cycle.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_pl4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [XLEN-1:0] fetch_pc, inflight_pc;
    logic            inflight, byp, xfer, push, pop_q;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

`ifdef FETCH_BYPASS_EN
    assign byp = (count == '0) && inflight;
`else
    assign byp = 1'b0;
`endif

    assign imem_addr = fetch_pc;

    // Credit counts the in-flight read so a response always has a free slot.
    always_comb begin
        out_valid  = rst & ((count != '0) | byp);
        xfer       = out_valid & out_ready;
        pop_q      = xfer & ~byp;
        push       = inflight & ~redirect_valid & ~(byp & out_ready);
        occ        = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(xfer);
        imem_req   = rst & ~redirect_valid & (occ < (CW+1)'(DEPTH));
        out_instr  = !rst ? '0 : byp ? imem_rdata : q_instr[rd_ptr];
        out_pc     = !rst ? '0 : byp ? inflight_pc : q_pc[rd_ptr];
        out_pc_pl4 = out_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
            count <= count + CW'(push) - CW'(pop_q);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_q) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) inflight_pc <= fetch_pc;
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        ((CW+1)'(count) + (CW+1)'(inflight)) <= (CW+1)'(DEPTH));
endmodule
